// File: rtl/mbinit_partner_seq.sv
// mbinit_partner_seq: partner-side MBINIT sideband responder that walks
// NUM_STEPS request/response pairs in order and flags completion.
// Ports: CLK, rst (sync, active-high), i_enable, i_RX_SbMessage,
//   i_msg_valid, i_Busy_SideBand, i_falling_edge_busy -> o_TX_SbMessage,
//   o_ValidOutData, o_step_idx, o_end, o_error.
// Optional: define MBINIT_PARTNER_TIMEOUT_EN for a per-step timeout to ERROR.
module mbinit_partner_seq #(
   parameter int                         MSG_W          = 4,
   parameter int                         NUM_STEPS      = 2,
   parameter logic [NUM_STEPS*MSG_W-1:0] REQ_CODES      = {4'h3, 4'h1},
   parameter logic [NUM_STEPS*MSG_W-1:0] RESP_CODES     = {4'h4, 4'h2},
   parameter int                         TIMEOUT_CYCLES = 16,
   parameter int                         STEP_W         = 3
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              i_enable,
   input  logic [MSG_W-1:0]  i_RX_SbMessage,
   input  logic              i_msg_valid,
   input  logic              i_Busy_SideBand,
   input  logic              i_falling_edge_busy,
   output logic [MSG_W-1:0]  o_TX_SbMessage,
   output logic              o_ValidOutData,
   output logic [STEP_W-1:0] o_step_idx,
   output logic              o_end,
   output logic              o_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_REQ,
      S_WAIT_FREE,
      S_SEND_RESP,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int                TAB_N = 1 << STEP_W;
   localparam logic [STEP_W-1:0] LAST  = STEP_W'(NUM_STEPS - 1);

   generate
      if (NUM_STEPS < 1 || NUM_STEPS > 8 || TAB_N < NUM_STEPS ||
          TIMEOUT_CYCLES < 2) begin : g_bad_param
         $error("mbinit_partner_seq: illegal parameter set");
      end
   endgenerate

   // Code tables padded to a power of two so any step value indexes safely.
   logic [MSG_W-1:0] req_tab  [TAB_N];
   logic [MSG_W-1:0] resp_tab [TAB_N];

   generate
      for (genvar k = 0; k < TAB_N; k++) begin : g_tab
         if (k < NUM_STEPS) begin : g_used
            assign req_tab[k]  = REQ_CODES[k*MSG_W +: MSG_W];
            assign resp_tab[k] = RESP_CODES[k*MSG_W +: MSG_W];
         end else begin : g_pad
            assign req_tab[k]  = '0;
            assign resp_tab[k] = '0;
         end
      end
   endgenerate

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              req_hit, step_done;

   logic [MSG_W-1:0]  tx_d;
   logic              vld_d, end_d, err_d;

`ifdef MBINIT_PARTNER_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             active, tmr_exp;

   assign active  = (state_q == S_WAIT_REQ) || (state_q == S_WAIT_FREE) ||
                    (state_q == S_SEND_RESP);
   assign tmr_exp = active && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
`endif

   assign req_hit   = i_msg_valid && (i_RX_SbMessage == req_tab[step_q]);
   assign step_done = (state_q == S_SEND_RESP) && i_falling_edge_busy;

   // State register; outputs are registered from the next-state decode.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q        <= S_IDLE;
         step_q         <= '0;
         o_TX_SbMessage <= '0;
         o_ValidOutData <= 1'b0;
         o_step_idx     <= '0;
         o_end          <= 1'b0;
         o_error        <= 1'b0;
`ifdef MBINIT_PARTNER_TIMEOUT_EN
         tmr_q          <= '0;
`endif
      end else begin
         state_q        <= state_d;
         step_q         <= step_d;
         o_TX_SbMessage <= tx_d;
         o_ValidOutData <= vld_d;
         o_step_idx     <= step_d;
         o_end          <= end_d;
         o_error        <= err_d;
`ifdef MBINIT_PARTNER_TIMEOUT_EN
         tmr_q          <= tmr_d;
`endif
      end
   end

   // Next-state logic; a dropped enable overrides everything.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      if (!i_enable) begin
         state_d = S_IDLE;
         step_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_WAIT_REQ;
               step_d  = '0;
            end
            S_WAIT_REQ:
               if (req_hit) state_d = S_WAIT_FREE;
            S_WAIT_FREE:
               if (!i_Busy_SideBand) state_d = S_SEND_RESP;
            S_SEND_RESP:
               if (step_done) begin
                  if (step_q == LAST) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_WAIT_REQ;
                     step_d  = step_q + STEP_W'(1);
                  end
               end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
         endcase
`ifdef MBINIT_PARTNER_TIMEOUT_EN
         // A step finishing on the terminal count beats the timeout.
         if (tmr_exp && !step_done) state_d = S_ERROR;
`endif
      end
   end

`ifdef MBINIT_PARTNER_TIMEOUT_EN
   // Timer restarts whenever a step (re)enters WAIT_REQ.
   always_comb begin
      tmr_d = '0;
      if (state_d == S_WAIT_REQ && state_q != S_WAIT_REQ)
         tmr_d = '0;
      else if (active)
         tmr_d = tmr_q + TMR_W'(1);
   end
`endif

   // Output decode from the next state.
   always_comb begin
      tx_d  = '0;
      vld_d = 1'b0;
      end_d = (state_d == S_DONE);
      err_d = (state_d == S_ERROR);
      if (state_d == S_SEND_RESP) begin
         tx_d  = resp_tab[step_d];
         vld_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_mbinit_partner_seq.sv
// tb_mbinit_partner_seq: directed plus random stimulus for mbinit_partner_seq
// with a cycle-level reference model of the request/response walk.
module tb_mbinit_partner_seq;

   logic       CLK = 1'b0;
   logic       rst;
   logic       i_enable;
   logic [3:0] i_RX_SbMessage;
   logic       i_msg_valid;
   logic       i_Busy_SideBand;
   logic       i_falling_edge_busy;
   logic [3:0] o_TX_SbMessage;
   logic       o_ValidOutData;
   logic [2:0] o_step_idx;
   logic       o_end;
   logic       o_error;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: step list as plain arrays, progress as (phase, step).
   // phase: 0 idle, 1 awaiting request, 2 awaiting free bus,
   //        3 sending response, 4 finished.
   logic [3:0] req_list  [2] = '{4'h1, 4'h3};
   logic [3:0] resp_list [2] = '{4'h2, 4'h4};
   int m_phase = 0;
   int m_step  = 0;

   always #5 CLK = ~CLK;

   mbinit_partner_seq dut (
      .CLK                 (CLK),
      .rst                 (rst),
      .i_enable            (i_enable),
      .i_RX_SbMessage      (i_RX_SbMessage),
      .i_msg_valid         (i_msg_valid),
      .i_Busy_SideBand     (i_Busy_SideBand),
      .i_falling_edge_busy (i_falling_edge_busy),
      .o_TX_SbMessage      (o_TX_SbMessage),
      .o_ValidOutData      (o_ValidOutData),
      .o_step_idx          (o_step_idx),
      .o_end               (o_end),
      .o_error             (o_error)
   );

   task automatic model_step();
      if (rst || !i_enable) begin
         m_phase = 0;
         m_step  = 0;
      end else if (m_phase == 0) begin
         m_phase = 1;
         m_step  = 0;
      end else if (m_phase == 1) begin
         if (i_msg_valid && i_RX_SbMessage == req_list[m_step]) m_phase = 2;
      end else if (m_phase == 2) begin
         if (!i_Busy_SideBand) m_phase = 3;
      end else if (m_phase == 3) begin
         if (i_falling_edge_busy) begin
            if (m_step == 1) m_phase = 4;
            else begin
               m_step  = m_step + 1;
               m_phase = 1;
            end
         end
      end
   endtask

   task automatic check(string tag);
      logic [3:0] e_tx;
      logic       e_vld;
      logic [2:0] e_idx;
      logic       e_end;
      e_vld = (m_phase == 3);
      e_tx  = e_vld ? resp_list[m_step] : 4'h0;
      e_idx = 3'(m_step);
      e_end = (m_phase == 4);
      n_cmp++;
      assert (o_TX_SbMessage === e_tx) else begin
         n_bad++;
         $error("FAIL %s tx: got %h exp %h", tag, o_TX_SbMessage, e_tx);
      end
      n_cmp++;
      assert (o_ValidOutData === e_vld) else begin
         n_bad++;
         $error("FAIL %s valid: got %b exp %b", tag, o_ValidOutData, e_vld);
      end
      n_cmp++;
      assert (o_step_idx === e_idx) else begin
         n_bad++;
         $error("FAIL %s step: got %0d exp %0d", tag, o_step_idx, e_idx);
      end
      n_cmp++;
      assert (o_end === e_end) else begin
         n_bad++;
         $error("FAIL %s end: got %b exp %b", tag, o_end, e_end);
      end
      n_cmp++;
      assert (o_error === 1'b0) else begin
         n_bad++;
         $error("FAIL %s error: got %b exp 0", tag, o_error);
      end
   endtask

   task automatic cyc(string tag);
      @(posedge CLK);
      model_step();
      #1;
      check(tag);
   endtask

   initial begin
      rst = 1'b1;
      i_enable = 1'b0;
      i_RX_SbMessage = 4'h0;
      i_msg_valid = 1'b0;
      i_Busy_SideBand = 1'b0;
      i_falling_edge_busy = 1'b0;
      cyc("reset");
      cyc("reset");
      rst = 1'b0;

      // Full two-step walk.
      i_enable = 1'b1;
      cyc("t1_en");
      i_RX_SbMessage = 4'h1; i_msg_valid = 1'b1;
      cyc("t1_req0");
      i_msg_valid = 1'b0;
      cyc("t1_send0");
      cyc("t1_send0b");
      i_falling_edge_busy = 1'b1;
      cyc("t1_fe0");
      i_falling_edge_busy = 1'b0;
      i_RX_SbMessage = 4'h3; i_msg_valid = 1'b1;
      cyc("t1_req1");
      i_msg_valid = 1'b0;
      cyc("t1_send1");
      cyc("t1_send1b");
      i_falling_edge_busy = 1'b1;
      cyc("t1_done");
      i_falling_edge_busy = 1'b0;
      cyc("t1_hold");
      cyc("t1_hold");

      // Out-of-order request is ignored.
      i_enable = 1'b0;
      cyc("t2_dis");
      i_enable = 1'b1;
      cyc("t2_en");
      i_RX_SbMessage = 4'h3; i_msg_valid = 1'b1;
      cyc("t2_wrong");
      i_RX_SbMessage = 4'h1;
      cyc("t2_right");
      i_msg_valid = 1'b0;
      cyc("t2_send");
      i_falling_edge_busy = 1'b1;
      cyc("t2_fe");
      i_falling_edge_busy = 1'b0;

      // Busy sideband holds off the response.
      i_Busy_SideBand = 1'b1;
      i_RX_SbMessage = 4'h3; i_msg_valid = 1'b1;
      cyc("t3_req");
      i_msg_valid = 1'b0;
      repeat (5) cyc("t3_busy");
      i_Busy_SideBand = 1'b0;
      cyc("t3_free");
      cyc("t3_send");

      // Enable drop during step 1 response.
      i_enable = 1'b0;
      cyc("t4_abort");
      i_enable = 1'b1;
      cyc("t4_re");
      cyc("t4_wait");

      // Reset mid-handshake, stale pulse afterwards.
      i_RX_SbMessage = 4'h1; i_msg_valid = 1'b1;
      cyc("t5_req");
      i_msg_valid = 1'b0;
      cyc("t5_send");
      rst = 1'b1;
      cyc("t5_rst");
      rst = 1'b0;
      i_falling_edge_busy = 1'b1;
      cyc("t5_stale");
      i_falling_edge_busy = 1'b0;
      cyc("t5_after");

      // Long wait for a request: no error in the default build.
      repeat (40) cyc("t6_wait");

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         rst                 = ($urandom_range(0, 99) == 0);
         i_enable            = ($urandom_range(0, 39) != 0);
         i_msg_valid         = ($urandom_range(0, 1) == 1);
         i_RX_SbMessage      = 4'($urandom_range(0, 4));
         i_Busy_SideBand     = ($urandom_range(0, 2) == 0);
         i_falling_edge_busy = ($urandom_range(0, 3) == 0);
         cyc("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
